// File: rtl/hba_master_ctrl.sv
// HBA bus master: turns one local request into one HBA read/write transaction
// and returns read data or a timeout error on a response handshake.
module hba_master_ctrl #(
   parameter int DBUS_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rnw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DBUS_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DBUS_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  hba_select,
   output logic                  hba_rnw,
   output logic [ADDR_WIDTH-1:0] hba_abus,
   output logic [DBUS_WIDTH-1:0] hba_dbus,
   input  logic                  hba_xferack,
   input  logic [DBUS_WIDTH-1:0] hba_dbus_in
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   logic [7:0]            r_cnt;
   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic [DBUS_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_hba_select;
   logic                  r_hba_rnw;
   logic [ADDR_WIDTH-1:0] r_hba_abus;
   logic [DBUS_WIDTH-1:0] r_hba_dbus;

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 8'd0;
         r_req_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
         r_hba_select <= 1'b0;
         r_hba_rnw    <= 1'b0;
         r_hba_abus   <= '0;
         r_hba_dbus   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_req_ready <= 1'b1;
               // req_ready is 0 on the first edge after reset, so no accept there
               if (req_valid && r_req_ready) begin
                  r_hba_select <= 1'b1;
                  r_hba_rnw    <= req_rnw;
                  r_hba_abus   <= req_addr;
                  r_hba_dbus   <= req_rnw ? '0 : req_wdata;
                  r_req_ready  <= 1'b0;
                  r_cnt        <= 8'd0;
                  r_state      <= ST_XFER;
               end
            end

            ST_XFER: begin
               // Ack is checked first so it wins over a simultaneous timeout
               if (hba_xferack) begin
                  r_rsp_rdata  <= r_hba_rnw ? hba_dbus_in : '0;
                  r_rsp_err    <= 1'b0;
                  r_rsp_valid  <= 1'b1;
                  r_hba_select <= 1'b0;
                  r_hba_rnw    <= 1'b0;
                  r_hba_abus   <= '0;
                  r_hba_dbus   <= '0;
                  r_state      <= ST_RESP;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_rsp_rdata  <= '0;
                  r_rsp_err    <= 1'b1;
                  r_rsp_valid  <= 1'b1;
                  r_hba_select <= 1'b0;
                  r_hba_rnw    <= 1'b0;
                  r_hba_abus   <= '0;
                  r_hba_dbus   <= '0;
                  r_state      <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_err    = r_rsp_err;
   assign hba_select = r_hba_select;
   assign hba_rnw    = r_hba_rnw;
   assign hba_abus   = r_hba_abus;
   assign hba_dbus   = r_hba_dbus;

endmodule

// File: tb/tb_hba_master_ctrl.sv
// Randomized bench for hba_master_ctrl with a programmable-latency slave and
// a transaction-level reference model of memory, latency and timeout.
module tb_hba_master_ctrl;

   localparam int DW = 8;
   localparam int AW = 12;
   localparam int T  = 8;

   logic          hba_clk;
   logic          hba_reset_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_rnw;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          hba_select;
   logic          hba_rnw;
   logic [AW-1:0] hba_abus;
   logic [DW-1:0] hba_dbus;
   logic          hba_xferack;
   logic [DW-1:0] hba_dbus_in;

   hba_master_ctrl #(
      .DBUS_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(T)
   ) u_dut (
      .hba_clk    (hba_clk),
      .hba_reset_n(hba_reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rnw    (req_rnw),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .hba_select (hba_select),
      .hba_rnw    (hba_rnw),
      .hba_abus   (hba_abus),
      .hba_dbus   (hba_dbus),
      .hba_xferack(hba_xferack),
      .hba_dbus_in(hba_dbus_in)
   );

   initial hba_clk = 1'b0;
   always #5 hba_clk = ~hba_clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Slave: acks in select cycle ack_cycle (1-based); 0 means no slave answers
   logic [DW-1:0] slv_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            ack_cycle  = 0;
   int            sel_cnt    = 0;
   logic          stray      = 1'b0;
   logic [DW-1:0] stray_data = '0;
   logic          w_slv_ack;

   assign w_slv_ack   = hba_select && (ack_cycle > 0) && (sel_cnt == ack_cycle - 1);
   assign hba_xferack = w_slv_ack | stray;
   assign hba_dbus_in = (w_slv_ack && hba_rnw) ? slv_mem[hba_abus] : (stray ? stray_data : '0);

   always @(posedge hba_clk) begin
      sel_cnt <= hba_select ? sel_cnt + 1 : 0;
      if (w_slv_ack && !hba_rnw) slv_mem[hba_abus] <= hba_dbus;
   end

   // Select must be low for at least two sampled cycles before each rise
   int   low_cnt  = 10;
   logic prev_sel = 1'b0;
   always @(negedge hba_clk) begin
      if (hba_select && !prev_sel) check_val("sel_gap", 32'(low_cnt >= 2), 32'd1);
      low_cnt  = hba_select ? 0 : low_cnt + 1;
      prev_sel = hba_select;
   end

   // Called aligned to a negedge with the DUT idle; returns aligned to a negedge, idle again
   task automatic do_txn(input logic rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int ackc, input int bp);
      logic          ok;
      int            exp_sel;
      int            sel_cyc;
      logic [DW-1:0] exp_rd;
      ok      = (ackc >= 1) && (ackc <= T);
      exp_sel = ok ? ackc : T;
      exp_rd  = (ok && rnw) ? ref_mem[addr] : '0;
      if (ok && !rnw) ref_mem[addr] = wd;

      check_val("idle_ready", req_ready, 1);
      ack_cycle = ackc;
      rsp_ready = (bp == 0);
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_wdata = wd;
      @(negedge hba_clk);
      req_valid = 1'b0;
      sel_cyc   = 0;
      while (hba_select === 1'b1 && sel_cyc < 300) begin
         sel_cyc++;
         check_val("bus_abus", hba_abus, addr);
         check_val("bus_rnw", hba_rnw, rnw);
         check_val("bus_dbus", hba_dbus, rnw ? 8'h00 : wd);
         check_val("busy_ready", req_ready, 0);
         @(negedge hba_clk);
      end
      check_val("sel_cycles", sel_cyc, exp_sel);
      check_val("rsp_valid", rsp_valid, 1);
      check_val("rsp_err", rsp_err, !ok);
      check_val("rsp_rdata", rsp_rdata, exp_rd);
      check_val("bus_idle_abus", hba_abus, 0);
      check_val("bus_idle_dbus", hba_dbus, 0);
      for (int i = 0; i < bp; i++) begin
         req_valid  = 1'b1;
         req_rnw    = 1'($urandom_range(0, 1));
         req_addr   = AW'($urandom);
         req_wdata  = DW'($urandom);
         stray      = 1'($urandom_range(0, 1));
         stray_data = DW'($urandom);
         @(negedge hba_clk);
         check_val("hold_valid", rsp_valid, 1);
         check_val("hold_rdata", rsp_rdata, exp_rd);
         check_val("hold_err", rsp_err, !ok);
         check_val("hold_ready", req_ready, 0);
         check_val("hold_sel", hba_select, 0);
      end
      req_valid = 1'b0;
      stray     = 1'b0;
      rsp_ready = 1'b1;
      @(negedge hba_clk);
      check_val("done_valid", rsp_valid, 0);
      check_val("done_rdata", rsp_rdata, 0);
      check_val("done_err", rsp_err, 0);
      check_val("done_ready", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic          rnw;
      logic [AW-1:0] addr;
      int            r;
      int            ackc;
      for (int i = 0; i < (1 << AW); i++) begin
         slv_mem[i] = '0;
         ref_mem[i] = '0;
      end
      hba_reset_n = 1'b0;
      req_valid   = 1'b0;
      req_rnw     = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      rsp_ready   = 1'b1;
      repeat (3) @(negedge hba_clk);
      check_val("rst_ready", req_ready, 0);
      check_val("rst_valid", rsp_valid, 0);
      check_val("rst_sel", hba_select, 0);
      check_val("rst_abus", hba_abus, 0);
      hba_reset_n = 1'b1;
      @(negedge hba_clk);
      check_val("rel_ready", req_ready, 1);

      // Directed: standard write/read, back-to-back, timeout, backpressure, ack on last cycle
      do_txn(1'b0, 12'h001, 8'hA5, 4, 0);
      do_txn(1'b1, 12'h001, 8'h00, 4, 0);
      do_txn(1'b0, 12'h000, 8'h11, 4, 0);
      do_txn(1'b0, 12'h001, 8'h22, 4, 0);
      do_txn(1'b0, 12'h002, 8'h33, 4, 0);
      do_txn(1'b0, 12'h003, 8'h44, 4, 0);
      for (int a = 0; a < 4; a++) do_txn(1'b1, AW'(a), 8'h00, 4, 0);
      do_txn(1'b1, 12'hF00, 8'h00, 0, 3);
      do_txn(1'b0, 12'h007, 8'h5A, 4, 0);
      do_txn(1'b1, 12'h007, 8'h00, 4, 5);
      slv_mem[12'h009] = 8'h3C;
      ref_mem[12'h009] = 8'h3C;
      do_txn(1'b1, 12'h009, 8'h00, T, 0);
      do_txn(1'b1, 12'h009, 8'h00, T + 1, 2);

      // Reset two cycles after accept
      ack_cycle = 4;
      req_valid = 1'b1;
      req_rnw   = 1'b0;
      req_addr  = 12'h005;
      req_wdata = 8'h77;
      @(negedge hba_clk);
      req_valid = 1'b0;
      @(negedge hba_clk);
      #2 hba_reset_n = 1'b0;
      #1;
      check_val("arst_sel", hba_select, 0);
      check_val("arst_ready", req_ready, 0);
      check_val("arst_valid", rsp_valid, 0);
      @(negedge hba_clk);
      hba_reset_n = 1'b1;
      @(negedge hba_clk);
      check_val("arst_rel_ready", req_ready, 1);
      do_txn(1'b1, 12'h005, 8'h00, 4, 0);
      do_txn(1'b0, 12'h005, 8'h77, 4, 1);
      do_txn(1'b1, 12'h005, 8'h00, 4, 0);

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         rnw  = 1'($urandom_range(0, 1));
         addr = AW'($urandom_range(0, 15));
         r    = $urandom_range(0, 9);
         if (r < 5)       ackc = 4;
         else if (r < 7)  ackc = $urandom_range(1, T);
         else if (r == 7) ackc = T;
         else if (r == 8) ackc = 0;
         else             ackc = T + $urandom_range(1, 3);
         do_txn(rnw, addr, DW'($urandom), ackc, $urandom_range(0, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/hba_master_ctrl.md
Name: hba_master_ctrl

Overview:
- HBA bus master: the initiator end of the HBA slave protocol. It turns one request from a local command source (e.g. the UART/SPI command parser) into one HBA read or write transaction.
- It drives hba_select/hba_rnw/hba_abus/hba_dbus, waits for the OR-ed slave hba_xferack, and returns read data or a timeout error on a response handshake.
- Only one transaction is outstanding at a time. It is the sole master on the bus; arbitration is out of scope.

Parameters:
- DBUS_WIDTH, 8, data bus width.
- ADDR_WIDTH, 12, full bus address width (peripheral field plus register field).
- TIMEOUT_CYCLES, 255, number of hba_select-asserted cycles without ack before abort. Range 1..255.

Ports:
- hba_clk  in  1  bus clock; all logic on the rising edge.
- hba_reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_rnw  in  1  1=read, 0=write.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DBUS_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DBUS_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  1 = transaction timed out.
- hba_select  out  1  transfer in progress.
- hba_rnw  out  1  bus direction.
- hba_abus  out  ADDR_WIDTH  bus address.
- hba_dbus  out  DBUS_WIDTH  bus write data.
- hba_xferack  in  1  OR of slave acknowledges.
- hba_dbus_in  in  DBUS_WIDTH  OR of slave data buses.

Behaviour:
- Reset:
  - Asynchronous on hba_reset_n low, effective immediately, including mid-transaction.
  - State goes to IDLE.
  - req_ready, rsp_valid, rsp_err, rsp_rdata, hba_select, hba_rnw, hba_abus and hba_dbus all go to 0.
  - The timeout counter clears.
  - Release is synchronous to hba_clk.
- Outputs: all outputs are registered. Bus outputs are 0 whenever hba_select=0 (OR-bus convention).
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at an edge, register the following on that same edge, then go to XFER:
    - hba_select=1
    - hba_rnw=req_rnw
    - hba_abus=req_addr
    - hba_dbus = req_wdata for writes, 0 for reads
    - req_ready=0
    - counter=0
- XFER:
  - Bus outputs are held stable.
  - If hba_xferack=1:
    - rsp_rdata = hba_dbus_in for reads, 0 for writes.
    - rsp_err=0 and rsp_valid=1.
    - hba_select and all bus outputs go to 0 on that edge.
    - Go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: rsp_err=1, rsp_rdata=0, rsp_valid=1, bus outputs go to 0, go to RESP.
  - Else counter+1.
  - Ack and timeout in the same cycle: the ack wins.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held until rsp_valid&rsp_ready at an edge.
  - Then rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1, and state goes to IDLE.
  - req_ready stays 0 throughout RESP.
- Bus spacing:
  - hba_select is low for at least 2 cycles between transactions (RESP ≥1 cycle, then the IDLE accept cycle).
  - This guarantees the slave has finished its post-ack WAIT cycle before the next select.
- Late/stray ack: hba_xferack seen in IDLE or RESP is ignored, including a late ack after a timeout.
- Latency with a standard slave (3-cycle ack):
  - Accept edge N.
  - hba_select high N..N+3.
  - Ack sampled at edge N+4.
  - rsp_valid high from N+4.
  - Timeout path: rsp_valid at edge N+TIMEOUT_CYCLES.
- Counter: 8 bits wide, never wraps; it is bounded by TIMEOUT_CYCLES.

Test Plan:
- Write: req addr=0x001, wdata=0xA5, with a standard register-bank slave at PERIPH_ADDR=0 -> select high exactly 4 cycles, hba_dbus=0xA5 during select, rsp_valid at N+4 with rdata=0x00, err=0. A read of 0x001 then returns 0xA5.
- Read back-to-back: reads of 0x000..0x003 after writing 0x11,0x22,0x33,0x44, rsp_ready tied 1 -> rdata 0x11,0x22,0x33,0x44 in order, err=0. Select low ≥2 cycles between transactions, and each transaction completes.
- Timeout: read of 0xF00 (no slave), TIMEOUT_CYCLES=8 -> select high 8 cycles, rsp_valid at N+8 with err=1, rdata=0. A forced ack 2 cycles later is ignored.
- Response backpressure: rsp_ready held 0 for 5 cycles after a read returns 0x5A -> rsp_valid/rdata=0x5A held stable, req_ready=0, and a req_valid offered meanwhile is not accepted. rsp_ready=1 -> IDLE next cycle, request accepted.
- Ack on the timeout cycle: TIMEOUT_CYCLES=4 with ack forced on the 4th select cycle, hba_dbus_in=0x3C -> err=0, rdata=0x3C.
- Reset mid-transfer: assert hba_reset_n=0 two cycles after accept -> hba_select, req_ready and rsp_valid drop to 0 immediately (asynchronously). After release, req_ready=1 on the first edge and a new write completes normally.
